// File: rtl/nnrv_ex.sv
// nnrv execute/memory stage: ALU, jump link, and a two-state load/store sequencer
// driving a request/acknowledge RAM port and the register-file write port.
module nnrv_ex #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_op1,
    input  logic [XLEN-1:0] i_id_op2,
    input  logic [3:0]      i_id_type,
    input  logic [4:0]      i_id_rd,
    input  logic [3:0]      i_id_ram_mask,
    input  logic            i_id_sign,
    output logic            o_id_stall,
    output logic            o_reg_wr_en,
    output logic [4:0]      o_reg_wr_idx,
    output logic [XLEN-1:0] o_reg_wr_data,
    output logic            o_ram_req,
    output logic            o_ram_we,
    output logic [XLEN-1:0] o_ram_addr,
    output logic [XLEN-1:0] o_ram_wdata,
    output logic [3:0]      o_ram_be,
    input  logic            i_ram_ack,
    input  logic [XLEN-1:0] i_ram_rdata
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MEM  = 1'b1;

    localparam logic [3:0] T_ADD   = 4'd1;
    localparam logic [3:0] T_SUB   = 4'd2;
    localparam logic [3:0] T_SLT   = 4'd3;
    localparam logic [3:0] T_SLTU  = 4'd4;
    localparam logic [3:0] T_XOR   = 4'd5;
    localparam logic [3:0] T_OR    = 4'd6;
    localparam logic [3:0] T_AND   = 4'd7;
    localparam logic [3:0] T_SLL   = 4'd8;
    localparam logic [3:0] T_SRL   = 4'd9;
    localparam logic [3:0] T_SRA   = 4'd10;
    localparam logic [3:0] T_JMP   = 4'd11;
    localparam logic [3:0] T_LOAD  = 4'd12;
    localparam logic [3:0] T_STORE = 4'd13;

    logic [0:0]      state_reg;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [3:0]      be_reg;
    logic [3:0]      mask_reg;
    logic            sign_reg;
    logic            we_reg;
    logic [4:0]      rd_reg;

    logic            is_mem;
    logic            is_wb;
    logic [XLEN-1:0] alu_result;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] load_data;

    assign is_mem     = (i_id_type == T_LOAD) || (i_id_type == T_STORE);
    assign is_wb      = (i_id_type >= T_ADD) && (i_id_type <= T_JMP);
    // Lanes shifted past byte 3 simply fall off the 4-bit enable.
    assign be_next    = i_id_ram_mask << i_id_op2[1:0];
    assign wdata_next = i_id_op1 << {i_id_op2[1:0], 3'b000};

    always_comb begin
        alu_result = '0;
        case (i_id_type)
            T_ADD:   alu_result = i_id_op1 + i_id_op2;
            T_SUB:   alu_result = i_id_op1 - i_id_op2;
            T_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(i_id_op1) < $signed(i_id_op2)};
            T_SLTU:  alu_result = {{(XLEN-1){1'b0}}, i_id_op1 < i_id_op2};
            T_XOR:   alu_result = i_id_op1 ^ i_id_op2;
            T_OR:    alu_result = i_id_op1 | i_id_op2;
            T_AND:   alu_result = i_id_op1 & i_id_op2;
            T_SLL:   alu_result = i_id_op1 << i_id_op2[4:0];
            T_SRL:   alu_result = i_id_op1 >> i_id_op2[4:0];
            T_SRA:   alu_result = $signed(i_id_op1) >>> i_id_op2[4:0];
            T_JMP:   alu_result = i_id_pc + XLEN'(4);
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        load_word = i_ram_rdata >> {addr_reg[1:0], 3'b000};
        case (mask_reg)
            4'b0001: load_data = {{(XLEN-8){sign_reg & load_word[7]}}, load_word[7:0]};
            4'b0011: load_data = {{(XLEN-16){sign_reg & load_word[15]}}, load_word[15:0]};
            default: load_data = load_word;
        endcase
    end

    // Gated by reset so decode is never held while the stage is being cleared.
    assign o_id_stall = !i_rst && (((state_reg == IDLE) && is_mem) ||
                                   ((state_reg == MEM) && !i_ram_ack));

    assign o_ram_req   = (state_reg == MEM);
    assign o_ram_we    = (state_reg == MEM) && we_reg;
    assign o_ram_addr  = {addr_reg[XLEN-1:2], 2'b00};
    assign o_ram_wdata = wdata_reg;
    assign o_ram_be    = be_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            mask_reg      <= '0;
            sign_reg      <= 1'b0;
            we_reg        <= 1'b0;
            rd_reg        <= '0;
            o_reg_wr_en   <= 1'b0;
            o_reg_wr_idx  <= '0;
            o_reg_wr_data <= '0;
        end else begin
            o_reg_wr_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (is_mem) begin
                        addr_reg  <= i_id_op2;
                        wdata_reg <= wdata_next;
                        be_reg    <= be_next;
                        mask_reg  <= i_id_ram_mask;
                        sign_reg  <= i_id_sign;
                        we_reg    <= (i_id_type == T_STORE);
                        rd_reg    <= i_id_rd;
                        state_reg <= MEM;
                    end else if (is_wb && (i_id_rd != 5'd0)) begin
                        o_reg_wr_en   <= 1'b1;
                        o_reg_wr_idx  <= i_id_rd;
                        o_reg_wr_data <= alu_result;
                    end
                end
                default: begin
                    // Bundle still on the inputs during the ack cycle is ignored here.
                    if (i_ram_ack) begin
                        state_reg <= IDLE;
                        if (!we_reg && (rd_reg != 5'd0)) begin
                            o_reg_wr_en   <= 1'b1;
                            o_reg_wr_idx  <= rd_reg;
                            o_reg_wr_data <= load_data;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nnrv_ex.sv
// Randomised scoreboard bench for nnrv_ex: directed cases, random bundles,
// a latency-programmable RAM responder and a mid-access reset.
module tb_nnrv_ex;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_id_pc = '0, i_id_op1 = '0, i_id_op2 = '0;
    logic [3:0]  i_id_type = '0;
    logic [4:0]  i_id_rd = '0;
    logic [3:0]  i_id_ram_mask = '0;
    logic        i_id_sign = 1'b0;
    logic        o_id_stall, o_reg_wr_en;
    logic [4:0]  o_reg_wr_idx;
    logic [31:0] o_reg_wr_data;
    logic        o_ram_req, o_ram_we;
    logic [31:0] o_ram_addr, o_ram_wdata;
    logic [3:0]  o_ram_be;
    logic        i_ram_ack = 1'b0;
    logic [31:0] i_ram_rdata = '0;

    nnrv_ex dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_pc(i_id_pc), .i_id_op1(i_id_op1), .i_id_op2(i_id_op2),
        .i_id_type(i_id_type), .i_id_rd(i_id_rd), .i_id_ram_mask(i_id_ram_mask),
        .i_id_sign(i_id_sign), .o_id_stall(o_id_stall),
        .o_reg_wr_en(o_reg_wr_en), .o_reg_wr_idx(o_reg_wr_idx), .o_reg_wr_data(o_reg_wr_data),
        .o_ram_req(o_ram_req), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .o_ram_wdata(o_ram_wdata), .o_ram_be(o_ram_be),
        .i_ram_ack(i_ram_ack), .i_ram_rdata(i_ram_rdata)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cur_lat = 0;
    logic [31:0] mem_rdata = '0;

    always @(posedge i_clk) cyc = cyc + 1;

    typedef struct { logic [4:0] idx; logic [31:0] data; int cyc; } wr_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } mreq_t;
    wr_t   wr_q[$];
    mreq_t mq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on whole words and byte lanes.
    function automatic logic [31:0] ref_alu(input int t, input logic [31:0] pc,
                                            input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] r;
        sh = int'(b % 32);
        case (t)
            1:  return a + b;
            2:  return a - b;
            3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a | b;
            7:  return a & b;
            8:  return a << sh;
            9:  return a >> sh;
            10: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                return r;
            end
            11: return pc + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int msize(input logic [3:0] m);
        if (m == 4'b0001) return 1;
        if (m == 4'b0011) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [3:0] m, input int off);
        logic [3:0] be = '0;
        for (int k = 0; k < msize(m); k++)
            if (off + k < 4) be[off + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int off);
        logic [31:0] w = '0;
        for (int lane = 0; lane < 4; lane++)
            if (lane >= off) w[8*lane +: 8] = d[8*(lane-off) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off,
                                             input logic [3:0] m, input logic s);
        logic [31:0] v = '0;
        logic [31:0] keep;
        int n = msize(m);
        for (int k = 0; k < n; k++)
            if (off + k < 4) v[8*k +: 8] = rd[8*(off+k) +: 8];
        if (s && n < 4 && v[8*n-1]) begin
            keep = (32'd1 << (8*n)) - 32'd1;
            v = v | ~keep;
        end
        return v;
    endfunction

    // RAM responder: acks after cur_lat wait cycles; random acks while idle must be ignored.
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge i_clk);
            #2;
            if (o_ram_req) begin
                if (mq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ram_req_unexpected: actual=req required=no_req (cycle %0d)", cyc);
                end else begin
                    check("ram_addr", o_ram_addr, mq[0].addr);
                    check("ram_we", {31'd0, o_ram_we}, {31'd0, mq[0].we});
                    check("ram_be", {28'd0, o_ram_be}, {28'd0, mq[0].be});
                    check("ram_wdata", o_ram_wdata, mq[0].wdata);
                end
                if (wcnt >= cur_lat) begin
                    i_ram_ack = 1'b1;
                    i_ram_rdata = mem_rdata;
                    if (mq.size() != 0) void'(mq.pop_front());
                end else begin
                    i_ram_ack = 1'b0;
                    i_ram_rdata = $urandom;
                    wcnt++;
                end
            end else begin
                i_ram_ack = 1'($urandom_range(0, 1));
                i_ram_rdata = $urandom;
                wcnt = 0;
            end
        end
    end

    // Monitor: every register write must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_reg_wr_en) begin
                if (wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_unexpected: actual=idx %0d data %h required=no_write (cycle %0d)",
                             o_reg_wr_idx, o_reg_wr_data, cyc);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_idx", {27'd0, o_reg_wr_idx}, {27'd0, e.idx});
                    check("wr_data", o_reg_wr_data, e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Present one bundle at posedge+1 and follow it to completion.
    task automatic issue(input logic [3:0] t, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [3:0] m,
                         input logic s, input int lat, input logic [31:0] rdata);
        int stalls;
        bit acked;
        int off;
        mreq_t q;
        wr_t w;
        off = int'(b % 4);
        i_id_type = t; i_id_pc = pc; i_id_op1 = a; i_id_op2 = b;
        i_id_rd = rd; i_id_ram_mask = m; i_id_sign = s;
        cur_lat = lat; mem_rdata = rdata;
        if (t != 4'd12 && t != 4'd13) begin
            if (t >= 4'd1 && t <= 4'd11 && rd != 5'd0) begin
                w.idx = rd; w.data = ref_alu(int'(t), pc, a, b); w.cyc = cyc + 1;
                wr_q.push_back(w);
            end
            @(negedge i_clk);
            check("stall_alu", {31'd0, o_id_stall}, 32'd0);
            @(posedge i_clk); #1;
        end else begin
            q.addr = {b[31:2], 2'b00}; q.we = (t == 4'd13);
            q.be = ref_be(m, off); q.wdata = ref_wdata(a, off);
            mq.push_back(q);
            @(negedge i_clk);
            check("stall_accept", {31'd0, o_id_stall}, 32'd1);
            stalls = 1; acked = 0;
            for (int i = 0; i < 64 && !acked; i++) begin
                @(posedge i_clk);
                @(negedge i_clk);
                if (!o_id_stall) acked = 1;
                else stalls++;
            end
            if (!acked) begin
                $display("FAIL mem_timeout: actual=no_ack required=ack within %0d cycles", lat + 1);
                $fatal(1, "memory access never completed");
            end
            check("stall_cycles", stalls, lat + 1);
            if (t == 4'd12 && rd != 5'd0) begin
                w.idx = rd; w.data = ref_load(rdata, off, m, s); w.cyc = cyc + 1;
                wr_q.push_back(w);
            end
            @(posedge i_clk); #1;
            check("req_drop", {31'd0, o_ram_req}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, {31'd0, o_id_stall}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, o_reg_wr_en}, 32'd0);
        check({tag, "_wr_idx"}, {27'd0, o_reg_wr_idx}, 32'd0);
        check({tag, "_wr_data"}, o_reg_wr_data, 32'd0);
        check({tag, "_req"}, {31'd0, o_ram_req}, 32'd0);
        check({tag, "_we"}, {31'd0, o_ram_we}, 32'd0);
        check({tag, "_addr"}, o_ram_addr, 32'd0);
        check({tag, "_wdata"}, o_ram_wdata, 32'd0);
        check({tag, "_be"}, {28'd0, o_ram_be}, 32'd0);
    endtask

    initial begin
        logic [3:0] masks [3];
        masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b1111;

        // A LOAD bundle held during reset must not raise stall.
        i_id_type = 4'd12; i_id_op2 = 32'h0000_1234;
        #3;
        check_reset_outputs("rst");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("rst_hold");
        i_id_type = 4'd0;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        issue(4'd1,  32'h0, 32'd5, 32'hFFFF_FFFD, 5'd3, 4'b0001, 1'b0, 0, 32'h0);
        issue(4'd10, 32'h0, 32'h8000_0000, 32'd4, 5'd4, 4'b0001, 1'b0, 0, 32'h0);
        issue(4'd4,  32'h0, 32'd1, 32'hFFFF_FFFF, 5'd6, 4'b0001, 1'b0, 0, 32'h0);
        issue(4'd3,  32'h0, 32'd1, 32'hFFFF_FFFF, 5'd7, 4'b0001, 1'b0, 0, 32'h0);
        issue(4'd11, 32'h100, 32'h0, 32'h0, 5'd1, 4'b0001, 1'b0, 0, 32'h0);
        issue(4'd11, 32'h100, 32'h0, 32'h0, 5'd0, 4'b0001, 1'b0, 0, 32'h0);
        issue(4'd13, 32'h0, 32'h0000_00AB, 32'h0000_1003, 5'd9, 4'b0001, 1'b0, 3, 32'h0);
        issue(4'd12, 32'h0, 32'h0, 32'h0000_2002, 5'd5, 4'b0011, 1'b1, 1, 32'h8001_0000);
        issue(4'd12, 32'h0, 32'h0, 32'h0000_2002, 5'd5, 4'b0011, 1'b0, 0, 32'h8001_0000);
        issue(4'd12, 32'h0, 32'h0, 32'h0000_3003, 5'd8, 4'b1111, 1'b1, 0, 32'h8844_2211);

        for (int n = 0; n < 80; n++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            issue(4'($urandom_range(0, 15)), {$urandom} & 32'hFFFF_FFFC, $urandom,
                  ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
                  rd, masks[$urandom_range(0, 2)], 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom);
        end

        // Reset while a load is outstanding: everything clears at once, no write.
        cur_lat = 1000;
        i_id_type = 4'd12; i_id_op2 = 32'h0000_4001; i_id_rd = 5'd10;
        i_id_ram_mask = 4'b0001; i_id_sign = 1'b0;
        begin
            mreq_t q;
            q.addr = 32'h0000_4000; q.we = 1'b0; q.be = 4'b0010; q.wdata = i_id_op1 << 8;
            mq.push_back(q);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check("mid_req", {31'd0, o_ram_req}, 32'd1);
        #1 i_rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        mq.delete();
        i_id_type = 4'd0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        cur_lat = 0;
        @(posedge i_clk); #1;
        issue(4'd1, 32'h0, 32'd5, 32'hFFFF_FFFD, 5'd3, 4'b0001, 1'b0, 0, 32'h0);
        i_id_type = 4'd0;

        repeat (3) @(posedge i_clk);
        #1;
        check("wr_queue_empty", wr_q.size(), 32'd0);
        check("mem_queue_empty", mq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still_running required=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/nnrv_ex.md
# nnrv_ex

Execute/memory stage of the nnrv RISC-V core, consuming the per-cycle operation bundle (pc, op1, op2, type, rd, ram_mask, sign) that instruction decode registers every cycle. It performs ALU operations and jump link computation, runs load/store accesses over a request/acknowledge RAM port with a small state machine, and drives the register-file write port. While a memory access is outstanding it holds decode through a stall output.

## Interface
- XLEN, 32, data/address width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_id_pc  in  XLEN  pc of presented operation
- i_id_op1  in  XLEN  operand 1; store data for STORE
- i_id_op2  in  XLEN  operand 2; effective address for LOAD/STORE
- i_id_type  in  4  operation code: NOP=0, ADD=1, SUB=2, SLT=3, SLTU=4, XOR=5, OR=6, AND=7, SLL=8, SRL=9, SRA=10, JMP=11, LOAD=12, STORE=13; 14/15 treated as NOP
- i_id_rd  in  5  destination register
- i_id_ram_mask  in  4  unshifted size mask: 0001 byte, 0011 half, 1111 word
- i_id_sign  in  1  sign-extend load result
- o_id_stall  out  1  decode must hold its bundle
- o_reg_wr_en  out  1  register write strobe
- o_reg_wr_idx  out  5  register written
- o_reg_wr_data  out  XLEN  write data
- o_ram_req  out  1  access request
- o_ram_we  out  1  1 = write
- o_ram_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
- o_ram_wdata  out  XLEN  lane-aligned store data
- o_ram_be  out  4  byte enables
- i_ram_ack  in  1  access complete; rdata valid this cycle for reads
- i_ram_rdata  in  XLEN  read word

## Operation
- States: IDLE, MEM. Bundle accepted only in IDLE.
- IDLE, type ALU (1..10): result = op1 ⊕ op2; shifts use op2[4:0]; SRA arithmetic; SLT signed, SLTU unsigned, result 0/1. Write rd next edge.
- IDLE, JMP: write pc+4 to rd.
- IDLE, NOP/14/15: no write.
- IDLE, LOAD/STORE: capture addr=op2, data=op1, mask, sign, rd, we; go MEM.
- MEM: o_ram_req=1, o_ram_addr, o_ram_we, o_ram_be, o_ram_wdata held constant. On i_ram_ack: go IDLE; for LOAD write extracted data to rd at that edge.
- Lanes: off=addr[1:0]; be=(mask<<off)[3:0] (lanes beyond 3 dropped, no exception); wdata=op1<<(8·off).
- Load extract: w=rdata>>(8·off); byte: w[7:0], half: w[15:0], word: w; sign=1 sign-extends byte/half, else zero-extends.
- rd==0: o_reg_wr_en stays 0 for every type.
- No forwarding or hazard detection in this block.

## Timing
- Reset: state IDLE; o_reg_wr_en=0, o_reg_wr_idx=0, o_reg_wr_data=0, o_ram_req=0, o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, o_ram_be=0. o_id_stall=0 during reset.
- o_reg_wr_* registered; wr_en is a one-cycle pulse.
- ALU/JMP: bundle presented cycle N, write visible cycle N+1.
- o_id_stall combinational: 1 when (IDLE and type∈{LOAD,STORE}) or (MEM and !i_ram_ack); else 0.
- Memory: accept cycle N; o_ram_req from N+1 until the ack cycle inclusive; ack at cycle M → load write visible M+1, req low M+1.
- Ack cycle: stall drops, decode advances; the still-presented memory bundle is ignored (state MEM). The next bundle is evaluated at M+1.
- Zero-wait: ack at N+1 → 2 cycles per memory op.
- i_ram_ack in IDLE ignored.
- Reset mid-MEM: abort immediately, req drops asynchronously, no register write.

## Test plan
- ADD op1=5, op2=0xFFFFFFFD, rd=3 -> next cycle wr_en=1, idx=3, data=2; no stall.
- SRA op1=0x80000000, op2=4 -> 0xF8000000; SLTU op1=1, op2=0xFFFFFFFF -> 1; SLT same operands -> 0.
- JMP pc=0x100, rd=1 -> data=0x104; rd=0 -> wr_en stays 0.
- STORE op1=0x000000AB, op2=0x1003, mask=0001, ack after 3 cycles -> addr=0x1000, be=1000, wdata=0xAB000000, we=1, stall high 4 cycles, no register write.
- LOAD op2=0x2002, mask=0011, sign=1, rdata=0x80010000, rd=5 -> be=1100, wr data=0xFFFF8001; same with sign=0 -> 0x00008001; zero-wait ack -> two cycles.
- Assert i_rst while in MEM with req high -> all outputs return to reset values immediately; after release, following ADD executes normally.
